// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : CPU load/store to single-port synchronous memory bridge
// Rev 1.0 - initial release
// ============================================================================
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] MEM_addr,
  output logic        MEM_rden,
  output logic [31:0] MEM_Wdata,
  output logic [3:0]  MEM_Wmask,
  input  logic [31:0] MEM_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_READ    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_RESP    = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_err;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata_rep;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Misalignment and the reserved size code are both rejected before any memory strobe.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      SZ_BYTE: w_req_err = 1'b0;
      SZ_HALF: w_req_err = req_addr[0];
      SZ_WORD: w_req_err = (req_addr[1:0] != 2'b00);
      default: w_req_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)   w_next = S_RESP;
          else if (req_wr) w_next = S_WRITE;
          else             w_next = S_READ;
        end
      end
      S_WRITE:   w_next = S_RESP;
      S_READ:    w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    MEM_rden  = (r_state == S_READ);
    MEM_Wmask = (r_state == S_WRITE) ? w_mask : 4'b0000;
    MEM_Wdata = (r_state == S_WRITE) ? w_wdata_rep : 32'h0;
    MEM_addr  = r_addr;
    rsp_rdata = r_rdata;
    rsp_err   = r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
    end else if (w_accept) begin
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_size   <= req_size;
      r_signed <= req_signed;
    end
  end

  always_comb begin
    w_mask      = 4'b1111;
    w_wdata_rep = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_mask      = 4'b0001 << r_addr[1:0];
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_mask      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_mask      = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = MEM_rdata[7:0];
    case (r_addr[1:0])
      2'd0:    w_byte = MEM_rdata[7:0];
      2'd1:    w_byte = MEM_rdata[15:8];
      2'd2:    w_byte = MEM_rdata[23:16];
      default: w_byte = MEM_rdata[31:24];
    endcase
    w_half = r_addr[1] ? MEM_rdata[31:16] : MEM_rdata[15:0];
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = MEM_rdata;
    endcase
  end

  // Response registers load on the edge entering RESP and hold until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept && w_req_err) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b1;
    end else if (r_state == S_WRITE) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_rdata <= w_load;
      r_err   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_mem_access_unit : randomized + directed bench with transaction-level model
// Rev 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] MEM_addr;
  logic        MEM_rden;
  logic [31:0] MEM_Wdata;
  logic [3:0]  MEM_Wmask;
  logic [31:0] MEM_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .MEM_addr   (MEM_addr),
    .MEM_rden   (MEM_rden),
    .MEM_Wdata  (MEM_Wdata),
    .MEM_Wmask  (MEM_Wmask),
    .MEM_rdata  (MEM_rdata)
  );

  // Registered-read memory, 256 words, indexed by address bits [9:2].
  logic [31:0] mem [0:255];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= $urandom;
      mem_ready <= 1'b1;
    end else begin
      if (MEM_rden) MEM_rdata <= mem[MEM_addr[9:2]];
      for (int n = 0; n < 4; n++)
        if (MEM_Wmask[n]) mem[MEM_addr[9:2]][8*n +: 8] <= MEM_Wdata[8*n +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [3:0] exp_mask(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return 32'(d[7:0]) * 32'h01010101;
    if (sz == 2'd1) return 32'(d[15:0]) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  // Transaction model: one outstanding request, timeline counted in cycles since accept.
  bit          m_busy = 1'b0;
  int          m_phase = 0;
  int          m_lat = 0;
  bit          m_err = 1'b0;
  logic        m_wr = 1'b0;
  logic        m_sgn = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [31:0] h_rdata = 32'h0;
  logic        h_err = 1'b0;
  logic [31:0] h_addr = 32'h0;
  bit          e_ready, e_rsp, e_rden;
  logic [3:0]  e_wm;

  always @(negedge clk) begin
    if (reset) begin
      m_busy  = 1'b0;
      h_rdata = 32'h0;
      h_err   = 1'b0;
      h_addr  = 32'h0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err",   32'(rsp_err), 32'd0);
      chk("rst_mem_addr",  MEM_addr, 32'd0);
      chk("rst_mem_rden",  32'(MEM_rden), 32'd0);
      chk("rst_mem_wdata", MEM_Wdata, 32'd0);
      chk("rst_mem_wmask", 32'(MEM_Wmask), 32'd0);
    end else begin
      if (m_busy) m_phase++;
      e_ready = !m_busy;
      e_rsp   = m_busy && (m_phase == m_lat);
      e_rden  = m_busy && !m_err && !m_wr && (m_phase == 1);
      e_wm    = (m_busy && !m_err && m_wr && m_phase == 1) ? exp_mask(m_addr, m_size) : 4'h0;
      if (e_rsp) begin
        h_err   = m_err;
        h_rdata = (m_err || m_wr) ? 32'h0 : extract(mem[m_addr[9:2]], m_addr, m_size, m_sgn);
      end
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("rsp_rdata", rsp_rdata, h_rdata);
      chk("rsp_err",   32'(rsp_err), 32'(h_err));
      chk("mem_addr",  MEM_addr, h_addr);
      chk("mem_rden",  32'(MEM_rden), 32'(e_rden));
      chk("mem_wmask", 32'(MEM_Wmask), 32'(e_wm));
      if (e_wm != 4'h0) chk("mem_wdata", MEM_Wdata, exp_wdata(m_wdata, m_size));
      if (e_rsp) m_busy = 1'b0;
      if (e_ready && req_valid) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_wr    = req_wr;
        m_addr  = req_addr;
        m_wdata = req_wdata;
        m_size  = req_size;
        m_sgn   = req_signed;
        m_err   = is_err(req_addr, req_size);
        m_lat   = m_err ? 1 : (req_wr ? 2 : 3);
        h_addr  = req_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t_rd, t_wd;
  logic        t_er;
  logic [3:0]  t_wm;
  int          t_lat, t_nr, t_nw;

  // Issues one request from IDLE, observes it to completion, returns in the following IDLE cycle.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic sg, input bit noise);
    chk("idle_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
    req_size = sz; req_signed = sg;
    step();
    req_valid = 1'b0;
    t_lat = 0; t_nr = 0; t_nw = 0; t_wm = 4'h0; t_wd = 32'h0; t_rd = 'x; t_er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (MEM_rden) t_nr++;
      if (MEM_Wmask != 4'h0) begin t_nw++; t_wm = MEM_Wmask; t_wd = MEM_Wdata; end
      if (rsp_valid) begin
        t_lat = k; t_rd = rsp_rdata; t_er = rsp_err; req_valid = 1'b0;
        break;
      end
      if (noise) begin
        req_valid  = 1'($urandom_range(0, 1));
        req_wr     = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (t_lat == 0) chk("rsp_within_8_cycles", 32'd0, 32'd1);
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    reset = 1'b0;

    // Byte store into the top lane.
    txn(1'b1, 32'h103, 32'h000000AB, 2'd0, 1'b0, 1'b0);
    chk("sb_wmask", 32'(t_wm), 32'h8);
    chk("sb_wdata", t_wd, 32'hABABABAB);
    chk("sb_latency", t_lat, 32'd2);
    chk("sb_err", 32'(t_er), 32'd0);
    chk("sb_rdata", t_rd, 32'd0);
    chk("sb_wmask_cycles", t_nw, 32'd1);
    chk("sb_addr_hold", MEM_addr, 32'h103);

    // Half loads, signed then unsigned.
    txn(1'b1, 32'h200, 32'h80011234, 2'd2, 1'b0, 1'b0);
    chk("sw_wmask", 32'(t_wm), 32'hF);
    txn(1'b0, 32'h202, 32'h0, 2'd1, 1'b1, 1'b0);
    chk("lh_signed", t_rd, 32'hFFFF8001);
    chk("lh_latency", t_lat, 32'd3);
    chk("lh_rden_cycles", t_nr, 32'd1);
    txn(1'b0, 32'h202, 32'h0, 2'd1, 1'b0, 1'b0);
    chk("lh_unsigned", t_rd, 32'h00008001);

    // Signed byte loads from lanes 1 and 0.
    txn(1'b1, 32'h0, 32'h00007F80, 2'd2, 1'b0, 1'b0);
    txn(1'b0, 32'h1, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("lb_lane1", t_rd, 32'h0000007F);
    txn(1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0);
    chk("lb_lane0", t_rd, 32'hFFFFFF80);

    // Misaligned word load and illegal size.
    txn(1'b0, 32'h6, 32'h0, 2'd2, 1'b0, 1'b0);
    chk("mis_latency", t_lat, 32'd1);
    chk("mis_err", 32'(t_er), 32'd1);
    chk("mis_rdata", t_rd, 32'd0);
    chk("mis_rden_cycles", t_nr, 32'd0);
    txn(1'b1, 32'h40, 32'h55, 2'd3, 1'b0, 1'b0);
    chk("ill_latency", t_lat, 32'd1);
    chk("ill_err", 32'(t_er), 32'd1);
    chk("ill_wmask_cycles", t_nw, 32'd0);

    // Reset during CAPTURE, then a word store right after release.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h200; req_size = 2'd2; req_signed = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rst_test_rden", 32'(MEM_rden), 32'd1);
    step();
    reset = 1'b1;
    #1;
    chk("async_rst_ready", 32'(req_ready), 32'd1);
    chk("async_rst_addr", MEM_addr, 32'd0);
    chk("async_rst_rdata", rsp_rdata, 32'd0);
    chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    step();
    reset = 1'b0;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
    chk("post_rst_wmask", 32'(t_wm), 32'hF);
    chk("post_rst_wdata", t_wd, 32'hDEADBEEF);
    chk("post_rst_latency", t_lat, 32'd2);

    // req_valid held high through a load: next accept only after RESP.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h200; req_size = 2'd2; req_signed = 1'b0;
    step();
    req_wr = 1'b1; req_addr = 32'h300; req_wdata = 32'h5A; req_size = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      chk("b2b_ready", 32'(req_ready), 32'(k == 4));
      if (k == 3) begin
        chk("b2b_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_rdata", rsp_rdata, 32'h80011234);
      end
      step();
    end
    req_valid = 1'b0;
    chk("b2b_store_wmask", 32'(MEM_Wmask), 32'h1);
    chk("b2b_store_wdata", MEM_Wdata, 32'h5A5A5A5A);
    step();
    step();

    // req_valid pulses during READ/CAPTURE are dropped.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h200; req_size = 2'd2;
    step();
    req_wr = 1'b1; req_addr = 32'h304; req_wdata = 32'hFF; req_size = 2'd0;
    step();
    step();
    req_valid = 1'b0;
    step();
    chk("ignored_ready", 32'(req_ready), 32'd1);
    chk("ignored_wmask", 32'(MEM_Wmask), 32'd0);
    step();
    chk("ignored_still_idle", 32'(req_ready), 32'd1);

    // Randomized traffic with bus noise while busy.
    for (int i = 0; i < 300; i++) begin
      logic        rw, rs;
      logic [31:0] ra, rd;
      logic [1:0]  rz;
      repeat ($urandom_range(0, 2)) step();
      rw = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      ra = 32'($urandom_range(0, 1023));
      rd = $urandom;
      rz = 2'($urandom_range(0, 3));
      txn(rw, ra, rd, rz, rs, bit'($urandom_range(0, 1)));
      chk("rand_latency", t_lat, is_err(ra, rz) ? 32'd1 : (rw ? 32'd2 : 32'd3));
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 req_valid  in  1  CPU load/store request present.
REQ-004 req_ready  out  1  unit idle, request accepted when req_valid&req_ready at clk edge.
REQ-005 req_wr  in  1  1=store, 0=load.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-009 req_signed  in  1  load sign-extends when 1, zero-extends when 0; ignored for word and for stores.
REQ-010 rsp_valid  out  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_rdata  out  32  right-aligned, extended load data; 0 for stores and errors.
REQ-012 rsp_err  out  1  misaligned or illegal size; valid with rsp_valid.
REQ-013 MEM_addr  out  32  byte address to memory (memory uses bits [31:2]).
REQ-014 MEM_rden  out  1  memory read enable.
REQ-015 MEM_Wdata  out  32  lane-replicated write data.
REQ-016 MEM_Wmask  out  4  byte write strobes, bit n = lane [8n+7:8n].
REQ-017 MEM_rdata  in  32  memory read word, registered by memory, valid the cycle after MEM_rden.

Function
REQ-018 States SHALL be IDLE, WRITE, READ, CAPTURE, RESP; req_ready=1 only in IDLE.
REQ-019 On accept, unit SHALL latch addr, size, signed, wr, wdata; later req_* changes have no effect.
REQ-020 Error check at accept: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> RESP with rsp_err=1, no memory strobe.
REQ-021 Legal store: IDLE->WRITE->RESP; Wmask nonzero exactly one cycle (WRITE); rsp_valid 2 cycles after accept edge.
REQ-022 Legal load: IDLE->READ->CAPTURE->RESP; MEM_rden=1 exactly one cycle (READ); MEM_rdata sampled at end of CAPTURE; rsp_valid 3 cycles after accept edge.
REQ-023 RESP lasts one cycle then IDLE; new request acceptable in the cycle after RESP.
REQ-024 Wmask: byte = 0001<<addr[1:0]; half = 0011 (addr[1]=0) or 1100 (addr[1]=1); word = 1111; 0000 outside WRITE.
REQ-025 Wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-026 Load extract: byte lane addr[1:0], half lane addr[1]; upper bits = sign bit if signed else 0.
REQ-027 MEM_rden=0 outside READ; MEM_rden and nonzero Wmask never asserted in the same cycle.
REQ-028 MEM_addr SHALL hold the latched request address from accept until next accept.
REQ-029 rsp_rdata/rsp_err SHALL hold value until next rsp_valid; rsp_rdata=0 on store or error response.
REQ-030 req_valid while not IDLE SHALL be ignored (not queued).

Reset
REQ-031 reset asserted: state=IDLE immediately; req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MEM_addr=0, MEM_rden=0, MEM_Wdata=0, MEM_Wmask=0.
REQ-032 reset mid-transaction SHALL drop it: no rsp_valid, no further strobes; first request accepted on first edge after deassertion.

Verification
REQ-033 Store byte addr=0x103 wdata=0x000000AB -> WRITE cycle Wmask=1000, Wdata=0xABABABAB, MEM_addr=0x103; rsp_valid 2 cycles later, rsp_err=0.
REQ-034 Load half signed addr=0x202, MEM_rdata=0x8001xxxx -> rden one cycle, rsp_rdata=0xFFFF8001 at 3 cycles; unsigned repeat -> 0x00008001.
REQ-035 Load byte signed addr=0x1, MEM_rdata=0x00007F80 -> rsp_rdata=0x0000007F; addr=0x0 -> 0xFFFFFF80.
REQ-036 Word load addr=0x6 and size=11 -> rsp_valid next cycle with rsp_err=1, rsp_rdata=0, MEM_rden and Wmask never asserted.
REQ-037 Reset asserted during CAPTURE -> outputs to reset values same cycle, no rsp_valid; post-reset word store addr=0x10 wdata=0xDEADBEEF -> Wmask=1111, Wdata=0xDEADBEEF.
REQ-038 Back-to-back: req_valid held high through a load -> second request accepted only in cycle after RESP; req_valid pulses in READ/CAPTURE ignored.
